mem_dump_reader: RTL and testbench
==================================

Name: mem_dump_reader

Overview:
- Readback engine on the memory side of the test/debug path. The memory-override path loads the memory image in bulk; this block walks an inclusive address range over a synchronous memory read port and streams each byte out over a valid/ready handshake.
- Lets the bench or a debug port compare memory contents against the model after a run.
- Sits between the system memory's secondary read port and the debug/monitor sink.

Parameters:
- REG_WIDTH, 8, data width of one memory word
- MEM_DEPTH, 256, number of memory words
- ADDR_WIDTH, 8, address width; must satisfy 2**ADDR_WIDTH >= MEM_DEPTH

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE
- start_addr  input  ADDR_WIDTH  first address to read; sampled with start
- end_addr  input  ADDR_WIDTH  last address to read (inclusive); sampled with start
- abort  input  1  terminate the dump at the next cycle
- mem_rd_en  output  1  memory read strobe
- mem_addr  output  ADDR_WIDTH  memory read address
- mem_rd_data  input  REG_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
- out_valid  output  1  out_data/out_addr/out_last are valid
- out_ready  input  1  sink accepts the current word
- out_data  output  REG_WIDTH  memory word
- out_addr  output  ADDR_WIDTH  address of out_data
- out_last  output  1  marks the final word of the range
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when a dump completes or is aborted
- err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal address and end registers 0.
- FSM states: IDLE, READ, WAIT, PRESENT, FINISH.
- IDLE, start=1:
  - if start_addr > end_addr or end_addr >= MEM_DEPTH: pulse err, stay in IDLE.
  - otherwise latch both addresses, cur=start_addr, go to READ.
- IDLE, start=0: hold.
- READ: mem_rd_en=1, mem_addr=cur for exactly one cycle; go to WAIT.
- WAIT: capture mem_rd_data into the output register; out_addr=cur; out_last=(cur==end_addr); go to PRESENT.
- PRESENT: out_valid=1; data, addr and last held stable until the handshake.
  - out_valid and out_ready both high: if out_last, go to FINISH; otherwise cur=cur+1 and go to READ.
  - out_valid must never drop without a handshake, except on abort or reset.
- FINISH: done=1 for one cycle; go to IDLE; busy drops in the same cycle IDLE is entered.
- Throughput: at most one word per 3 cycles. Latency from start to the first out_valid is 3 cycles.
- abort: takes priority in every non-IDLE state.
  - The next state is FINISH; out_valid drops in the following cycle; done pulses.
  - A word presented in the abort cycle with out_ready high counts as transferred.
  - abort in IDLE is ignored.
- start while busy: ignored, no err.
- Single-word range (start_addr==end_addr): one word with out_last=1.
- Address arithmetic is ADDR_WIDTH wide. cur never increments past end_addr, so it cannot wrap.
- Asynchronous reset mid-dump: immediately returns to IDLE with all outputs 0; no done pulse.
- mem_rd_data is ignored outside WAIT.

Optional Feature:
- Macro: MEM_DUMP_CHECKSUM_EN.
- When defined:
  - adds output checksum (REG_WIDTH bits): the running XOR of every word accepted by handshake in the current dump.
  - cleared to 0 on an accepted start.
  - final value valid in the done cycle and held until the next accepted start.
  - reset value 0.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Memory preloaded mem[i]=i^8'hA5; start, start_addr=8'h10, end_addr=8'h13, out_ready=1:
  - 4 words 8'hB5,8'hB4,8'hB7,8'hB6 at addrs 10..13; out_last only on 13.
  - done one cycle after the last handshake.
  - checksum=8'h00 when MEM_DUMP_CHECKSUM_EN is defined.
- start_addr=end_addr=8'h00, mem[0]=8'h3C: one word 8'h3C with out_last=1; first out_valid 3 cycles after start.
- Backpressure: out_ready held low 5 cycles on the 2nd word: out_data/out_addr stable, no extra mem_rd_en, sequence unchanged.
- start_addr=8'h20, end_addr=8'h1F: err pulse, busy stays 0, no mem_rd_en. Also end_addr=MEM_DEPTH (when 2**ADDR_WIDTH>MEM_DEPTH): err.
- abort asserted while the 3rd of 8 words is presented and out_ready=0: out_valid low next cycle, done pulses, busy low afterwards, exactly 2 words transferred.
- reset_n low during WAIT: all outputs 0 immediately; after release, a new start of range 0..1 works normally.

Source files
------------

// File: rtl/mem_dump_reader.sv
// Memory readback engine: walks an inclusive address range over a synchronous read port
// and streams each word out on a valid/ready handshake. Optional running XOR via MEM_DUMP_CHECKSUM_EN.
module mem_dump_reader #(
   parameter int REG_WIDTH  = 8,
   parameter int MEM_DEPTH  = 256,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH-1:0] end_addr,
   input  logic                  abort,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [REG_WIDTH-1:0]  mem_rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [REG_WIDTH-1:0]  out_data,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic                  err
`ifdef MEM_DUMP_CHECKSUM_EN
   ,
   output logic [REG_WIDTH-1:0]  checksum
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_PRESENT,
      S_FINISH
   } state_t;

   // One extra bit so a depth equal to 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cur_q, cur_d;
   logic [ADDR_WIDTH-1:0] end_q, end_d;
   logic [REG_WIDTH-1:0]  data_q, data_d;
   logic [ADDR_WIDTH-1:0] oaddr_q, oaddr_d;
   logic                  last_q, last_d;
   logic                  err_q, err_d;
   logic                  range_bad;
   logic                  handshake;
`ifdef MEM_DUMP_CHECKSUM_EN
   logic [REG_WIDTH-1:0]  csum_q, csum_d;
`endif

   assign range_bad = (start_addr > end_addr) || ({1'b0, end_addr} >= DEPTH_L);
   assign handshake = (state_q == S_PRESENT) && out_ready;

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      end_d   = end_q;
      data_d  = data_q;
      oaddr_d = oaddr_q;
      last_d  = last_q;
      err_d   = 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (range_bad) begin
                  err_d = 1'b1;
               end else begin
                  cur_d   = start_addr;
                  end_d   = end_addr;
                  state_d = S_READ;
`ifdef MEM_DUMP_CHECKSUM_EN
                  csum_d  = '0;
`endif
               end
            end
         end
         S_READ: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            data_d  = mem_rd_data;
            oaddr_d = cur_q;
            last_d  = (cur_q == end_q);
            state_d = S_PRESENT;
         end
         S_PRESENT: begin
            if (handshake) begin
               if (last_q) begin
                  state_d = S_FINISH;
               end else begin
                  cur_d   = cur_q + ADDR_WIDTH'(1);
                  state_d = S_READ;
               end
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A word accepted in the abort cycle still counts as transferred.
`ifdef MEM_DUMP_CHECKSUM_EN
      if (handshake) begin
         csum_d = csum_q ^ data_q;
      end
`endif
      if (abort && (state_q == S_READ || state_q == S_WAIT || state_q == S_PRESENT)) begin
         state_d = S_FINISH;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         end_q   <= '0;
         data_q  <= '0;
         oaddr_q <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         end_q   <= end_d;
         data_q  <= data_d;
         oaddr_q <= oaddr_d;
         last_q  <= last_d;
         err_q   <= err_d;
`ifdef MEM_DUMP_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign mem_rd_en = (state_q == S_READ);
   assign mem_addr  = cur_q;
   assign out_valid = (state_q == S_PRESENT);
   assign out_data  = data_q;
   assign out_addr  = oaddr_q;
   assign out_last  = last_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_FINISH);
   assign err       = err_q;
`ifdef MEM_DUMP_CHECKSUM_EN
   assign checksum  = csum_q;
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
// Randomized self-checking bench for mem_dump_reader: a queue-based reference model of the
// expected word stream is compared against what the sink actually accepts.
module tb_mem_dump_reader;

   localparam int RW    = 8;
   localparam int AW    = 8;
   localparam int DEPTH = 200;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [AW-1:0] end_addr;
   logic          abort;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [RW-1:0] mem_rd_data;
   logic          out_valid;
   logic          out_ready;
   logic [RW-1:0] out_data;
   logic [AW-1:0] out_addr;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          err;
`ifdef MEM_DUMP_CHECKSUM_EN
   logic [RW-1:0] checksum;
`endif

   always #5 clk = ~clk;

   mem_dump_reader #(
      .REG_WIDTH (RW),
      .MEM_DEPTH (DEPTH),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .start_addr (start_addr),
      .end_addr   (end_addr),
      .abort      (abort),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_rd_data(mem_rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_addr   (out_addr),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done),
      .err        (err)
`ifdef MEM_DUMP_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   // Synchronous memory: data one cycle after the strobe, garbage otherwise.
   logic [RW-1:0] mem [0:255];
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
      else           mem_rd_data <= RW'($urandom);
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [AW-1:0] a;
      logic [RW-1:0] d;
      logic          l;
   } word_t;

   word_t exp_q[$];
   word_t obs_q[$];

   task automatic run_dump(input logic [AW-1:0] sa, input logic [AW-1:0] ea, input int ready_pct,
                           input int stall_word, input int abort_word, input bit poke_start);
      bit            bad;
      int            n_exp, n_words, budget;
      int            first_v, hs_cyc, done_cyc, abort_cyc;
      int            rd_cnt, err_cnt, busy_cnt, stall_left;
      logic          pv, phs, pl;
      logic [RW-1:0] pd, csum_exp, csum_done;
      logic [AW-1:0] pa;
      word_t         w;
      bad = (sa > ea) || (int'(ea) >= DEPTH);
      exp_q.delete();
      obs_q.delete();
      if (!bad) begin
         for (int a = int'(sa); a <= int'(ea); a++) begin
            w.a = AW'(a);
            w.d = mem[a];
            w.l = (a == int'(ea));
            exp_q.push_back(w);
         end
      end
      n_exp  = exp_q.size();
      budget = 12 * (n_exp + 2) + 40;
      first_v = -1; hs_cyc = -1; done_cyc = -1; abort_cyc = -1;
      rd_cnt = 0; err_cnt = 0; busy_cnt = 0; stall_left = 5;
      pv = 1'b0; phs = 1'b0; pl = 1'b0; pd = '0; pa = '0; csum_done = '0;
      @(negedge clk);
      start = 1'b1; start_addr = sa; end_addr = ea; out_ready = 1'b0; abort = 1'b0;
      for (int cyc = 1; cyc < budget; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         if (poke_start && !bad && cyc == 4) begin
            start = 1'b1; start_addr = 8'h00; end_addr = 8'h00;
         end
         out_ready = ($urandom_range(99) < ready_pct);
         if (stall_word >= 0 && out_valid && obs_q.size() == stall_word && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end
         if (abort_word >= 0 && out_valid && obs_q.size() == abort_word) begin
            out_ready = 1'b0;
            abort     = 1'b1;
            abort_cyc = cyc;
         end
         if (mem_rd_en) rd_cnt++;
         if (err)       err_cnt++;
         if (busy)      busy_cnt++;
         if (out_valid && first_v < 0) first_v = cyc;
         if (out_valid && pv && !phs) begin
            check_eq("hold_data", out_data, pd);
            check_eq("hold_addr", out_addr, pa);
            check_eq("hold_last", out_last, pl);
         end
         if (out_valid && out_ready) begin
            w.a = out_addr; w.d = out_data; w.l = out_last;
            obs_q.push_back(w);
            hs_cyc = cyc;
         end
         pv = out_valid; phs = out_valid && out_ready;
         pd = out_data;  pa = out_addr;  pl = out_last;
         if (done && done_cyc < 0) begin
            done_cyc = cyc;
            check_eq("valid_in_done", out_valid, 0);
`ifdef MEM_DUMP_CHECKSUM_EN
            csum_done = checksum;
`endif
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            check_eq("busy_after_done", busy, 0);
            check_eq("done_one_cycle", done, 0);
            break;
         end
         if (bad && cyc == 6) break;
      end
      start = 1'b0;
      abort = 1'b0;
      if (bad) begin
         check_eq("err_pulses", err_cnt, 1);
         check_eq("err_busy", busy_cnt, 0);
         check_eq("err_rd_en", rd_cnt, 0);
      end else begin
         check_eq("done_seen", (done_cyc >= 0), 1);
         check_eq("first_valid_latency", first_v, 3);
         check_eq("no_err", err_cnt, 0);
         n_words = (abort_word >= 0) ? abort_word : n_exp;
         check_eq("word_count", obs_q.size(), n_words);
         csum_exp = '0;
         for (int i = 0; i < n_words && i < obs_q.size(); i++) begin
            check_eq("word_addr", obs_q[i].a, exp_q[i].a);
            check_eq("word_data", obs_q[i].d, exp_q[i].d);
            check_eq("word_last", obs_q[i].l, exp_q[i].l);
            csum_exp = csum_exp ^ exp_q[i].d;
         end
         if (abort_word >= 0) begin
            check_eq("abort_done_cyc", done_cyc, abort_cyc + 1);
            check_eq("abort_rd_cnt", rd_cnt, abort_word + 1);
         end else begin
            check_eq("done_after_last_hs", done_cyc, hs_cyc + 1);
            check_eq("rd_cnt", rd_cnt, n_exp);
         end
`ifdef MEM_DUMP_CHECKSUM_EN
         check_eq("checksum", csum_done, csum_exp);
`else
         if (csum_done != csum_exp) begin end
`endif
      end
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; start_addr = '0; end_addr = '0; abort = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = RW'(i) ^ 8'hA5;
      #12;
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_rd_en", mem_rd_en, 0);
      check_eq("rst_addr", mem_addr, 0);
      check_eq("rst_data", out_data, 0);
      check_eq("rst_last", out_last, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // abort in IDLE has no effect
      abort = 1'b1;
      repeat (2) @(negedge clk);
      abort = 1'b0;
      check_eq("idle_abort_busy", busy, 0);

      run_dump(8'h10, 8'h13, 100, -1, -1, 1'b0);
      check_eq("tp_w0", obs_q[0].d, 8'hB5);
      check_eq("tp_w1", obs_q[1].d, 8'hB4);
      check_eq("tp_w2", obs_q[2].d, 8'hB7);
      check_eq("tp_w3", obs_q[3].d, 8'hB6);
      check_eq("tp_last", obs_q[3].l, 1);

      mem[0] = 8'h3C;
      run_dump(8'h00, 8'h00, 100, -1, -1, 1'b0);
      check_eq("single_data", obs_q[0].d, 8'h3C);

      run_dump(8'h30, 8'h35, 100, 1, -1, 1'b0);  // backpressure on 2nd word
      run_dump(8'h20, 8'h1F, 100, -1, -1, 1'b0);  // start > end
      run_dump(8'h05, 8'(DEPTH), 100, -1, -1, 1'b0);  // end == depth
      run_dump(8'h40, 8'h47, 100, -1, 2, 1'b0);  // abort on 3rd of 8
      run_dump(8'h50, 8'h52, 100, -1, -1, 1'b1);  // start while busy

      // asynchronous reset during WAIT
      @(negedge clk);
      start = 1'b1; start_addr = 8'h00; end_addr = 8'h03;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", out_valid, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_done", done, 0);
      check_eq("mid_rst_rd_en", mem_rd_en, 0);
      check_eq("mid_rst_data", out_data, 0);
      check_eq("mid_rst_addr", out_addr, 0);
      check_eq("mid_rst_last", out_last, 0);
      @(negedge clk);
      reset_n = 1'b1;
      run_dump(8'h00, 8'h01, 100, -1, -1, 1'b0);

      // randomized dumps over random memory contents
      for (int i = 0; i < 256; i++) mem[i] = RW'($urandom);
      for (int t = 0; t < 24; t++) begin
         logic [AW-1:0] sa, ea;
         int            kind, abw;
         kind = $urandom_range(9);
         sa   = AW'($urandom_range(0, 180));
         ea   = AW'(int'(sa) + $urandom_range(0, 12));
         if (int'(ea) >= DEPTH) ea = AW'(DEPTH - 1);
         if (kind == 0) ea = (sa == 0) ? 8'h00 : sa - AW'($urandom_range(1, int'(sa)));
         if (kind == 1) ea = AW'($urandom_range(DEPTH, 255));
         if (kind == 0 && sa == 0) sa = 8'h01;
         abw = (kind == 2 && ea - sa >= 2) ? int'($urandom_range(0, int'(ea - sa))) : -1;
         run_dump(sa, ea, $urandom_range(40, 100), -1, abw, (kind == 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
